// File: rtl/reg_file_dumper_pkg.sv
// Shared types and constants for the register-file dump engine.
package reg_file_dumper_pkg;

    localparam int REG_ADDR_WIDTH     = 5;
    localparam int NUM_GPR            = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/reg_file_dumper_if.sv
// Valid/ready stream carrying dumped register words (and optional checksum beat).
interface reg_file_dumper_if
    import reg_file_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
);

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  out_csum;

    modport master (
        output out_valid, out_data, out_addr, out_last, out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_addr, out_last, out_csum,
        output out_ready
    );

endinterface

// File: rtl/reg_file_dumper.sv
// Walks the register file through one read port and streams every word out.
// Define REG_FILE_DUMPER_CSUM_EN to append an XOR checksum beat after the last register.
module reg_file_dumper
    import reg_file_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = NUM_GPR,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    reg_file_dumper_if.master     out_if
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_last_q, out_last_d;
    logic                  out_csum_q, out_csum_d;
    logic                  at_last;
    logic                  beat_taken;

`ifdef REG_FILE_DUMPER_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  csum_phase_q, csum_phase_d;
`endif

    assign at_last    = (index_q == LAST_IDX);
    assign beat_taken = out_valid_q && out_if.out_ready;

    // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_csum_d  = out_csum_q;
`ifdef REG_FILE_DUMPER_CSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d   = '0;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_FETCH;
`ifdef REG_FILE_DUMPER_CSUM_EN
                    csum_d       = '0;
                    csum_phase_d = 1'b0;
`endif
                end
            end

            ST_FETCH: begin
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
`ifdef REG_FILE_DUMPER_CSUM_EN
                if (csum_phase_q) begin
                    out_data_d = csum_q;
                    out_addr_d = '0;
                    out_last_d = 1'b1;
                    out_csum_d = 1'b1;
                end else begin
                    out_data_d = rd_data;
                    out_addr_d = index_q;
                    out_last_d = 1'b0;
                    out_csum_d = 1'b0;
                    csum_d     = csum_q ^ rd_data;
                end
`else
                out_data_d = rd_data;
                out_addr_d = index_q;
                out_last_d = at_last;
                out_csum_d = 1'b0;
`endif
            end

            ST_SEND: begin
                if (beat_taken) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
`ifdef REG_FILE_DUMPER_CSUM_EN
                        // After the final register the index parks; the next fetch emits the checksum.
                        if (at_last) begin
                            csum_phase_d = 1'b1;
                        end else begin
                            index_d   = index_q + ADDR_WIDTH'(1);
                            rd_addr_d = index_q + ADDR_WIDTH'(1);
                        end
`else
                        index_d   = index_q + ADDR_WIDTH'(1);
                        rd_addr_d = index_q + ADDR_WIDTH'(1);
`endif
                    end
                end
            end

            ST_DONE: begin
                busy_d    = 1'b0;
                index_d   = '0;
                rd_addr_d = '0;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state, including the output register, clears asynchronously so a reset mid-dump aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_csum_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_csum_q  <= out_csum_d;
        end
    end

`ifdef REG_FILE_DUMPER_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
        end else begin
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
        end
    end
`endif

    assign rd_addr          = rd_addr_q;
    assign busy             = busy_q;
    assign done             = (state_q == ST_DONE);
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_last  = out_last_q;
    assign out_if.out_csum  = out_csum_q;

endmodule
